// File: rtl/ltsm_sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband transmit channel among LTSM handshake
// requesters; issues each message, retries once on missing busy, reports completion.
module ltsm_sb_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int SB_MSG_WIDTH = 4,
    parameter int ACK_TIMEOUT  = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_flush,
    input  logic [N_REQ-1:0]                i_req,
    input  logic [N_REQ*SB_MSG_WIDTH-1:0]   i_msg,
    input  logic                            i_SB_Busy,
    output logic [SB_MSG_WIDTH-1:0]         o_encoded_SB_msg,
    output logic                            o_tx_msg_valid,
    output logic [N_REQ-1:0]                o_grant,
    output logic [N_REQ-1:0]                o_done,
    output logic                            o_timeout_err,
    output logic                            o_falling_edge_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_FREE, S_DONE} state_t;

    state_t                  r_state, w_state;
    logic [IDX_W-1:0]        r_ptr, w_ptr;
    logic [IDX_W-1:0]        r_win, w_win;
    logic [SB_MSG_WIDTH-1:0] r_msg, w_msg;
    logic [N_REQ-1:0]        r_grant, w_grant;
    logic [CNT_W-1:0]        r_cnt, w_cnt;
    logic                    r_retry, w_retry;
    logic                    r_busy_q;
    logic                    r_valid, w_valid;
    logic [SB_MSG_WIDTH-1:0] r_enc, w_enc;
    logic [N_REQ-1:0]        r_done, w_done;
    logic                    r_timeout, w_timeout;

    logic [SB_MSG_WIDTH-1:0] w_msg_arr [N_REQ];
    logic [IDX_W-1:0]        w_win_idx;
    logic [IDX_W-1:0]        w_cand;
    logic                    w_win_found;
    logic [IDX_W-1:0]        w_ptr_adv;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_fall;
    int                      w_scan;

    for (genvar g = 0; g < N_REQ; g++) begin : g_msg
        assign w_msg_arr[g] = i_msg[g*SB_MSG_WIDTH +: SB_MSG_WIDTH];
    end

    // Scan downward so the candidate closest to r_ptr is the last one written.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        w_scan      = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_scan = int'(r_ptr) + i;
            if (w_scan >= N_REQ) w_scan = w_scan - N_REQ;
            w_cand = IDX_W'(w_scan);
            if (i_req[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    assign w_ptr_adv = (r_win == IDX_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_fall    = r_busy_q & ~i_SB_Busy;

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_win     = r_win;
        w_msg     = r_msg;
        w_grant   = r_grant;
        w_cnt     = r_cnt;
        w_retry   = r_retry;
        w_valid   = 1'b0;
        w_enc     = '0;
        w_done    = '0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_found && !i_SB_Busy) begin
                    w_win   = w_win_idx;
                    w_msg   = w_msg_arr[w_win_idx];
                    w_grant = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;
                    w_valid = 1'b1;
                    w_enc   = w_msg_arr[w_win_idx];
                    w_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt   = '0;
                w_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Busy rising takes precedence over an expiring counter.
                if (i_SB_Busy) begin
                    w_state = S_WAIT_FREE;
                end else if (w_cnt_inc == CNT_W'(ACK_TIMEOUT - 1)) begin
                    w_cnt = '0;
                    if (!r_retry) begin
                        w_retry = 1'b1;
                        w_valid = 1'b1;
                        w_enc   = r_msg;
                        w_state = S_ISSUE;
                    end else begin
                        w_retry   = 1'b0;
                        w_timeout = 1'b1;
                        w_grant   = '0;
                        w_ptr     = w_ptr_adv;
                        w_state   = S_IDLE;
                    end
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            S_WAIT_FREE: begin
                if (w_fall) begin
                    w_done  = r_grant;
                    w_state = S_DONE;
                end
            end
            S_DONE: begin
                w_grant = '0;
                w_retry = 1'b0;
                w_ptr   = w_ptr_adv;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
        if (i_flush) begin
            w_state   = S_IDLE;
            w_grant   = '0;
            w_valid   = 1'b0;
            w_enc     = '0;
            w_cnt     = '0;
            w_retry   = 1'b0;
            w_done    = '0;
            w_timeout = 1'b0;
            w_ptr     = r_ptr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_retry   <= 1'b0;
            r_busy_q  <= 1'b0;
            r_valid   <= 1'b0;
            r_enc     <= '0;
            r_done    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_grant   <= w_grant;
            r_cnt     <= w_cnt;
            r_retry   <= w_retry;
            r_busy_q  <= i_SB_Busy;
            r_valid   <= w_valid;
            r_enc     <= w_enc;
            r_done    <= w_done;
            r_timeout <= w_timeout;
        end
    end

    // Winner index and message are only meaningful while o_grant is set.
    always_ff @(posedge i_clk) begin
        r_win <= w_win;
        r_msg <= w_msg;
    end

    assign o_encoded_SB_msg    = r_enc;
    assign o_tx_msg_valid      = r_valid;
    assign o_grant             = r_grant;
    assign o_done              = r_done;
    assign o_timeout_err       = r_timeout;
    assign o_falling_edge_busy = w_fall;

endmodule

// File: tb/tb_ltsm_sb_tx_arbiter.sv
// Directed bench for ltsm_sb_tx_arbiter: per-cycle vector table plus hand-written
// sequences for round-robin, timeout/retry, flush, coincident busy and async reset.
module tb_ltsm_sb_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int ATO = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic [N-1:0]   req;
    logic [N*W-1:0] msg;
    logic           busy;
    logic [W-1:0]   enc;
    logic           valid;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           tout;
    logic           fall;

    int n_chk  = 0;
    int n_fail = 0;
    int n_valid = 0;

    always #5 clk = ~clk;

    ltsm_sb_tx_arbiter #(.N_REQ(N), .SB_MSG_WIDTH(W), .ACK_TIMEOUT(ATO)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_flush             (flush),
        .i_req               (req),
        .i_msg               (msg),
        .i_SB_Busy           (busy),
        .o_encoded_SB_msg    (enc),
        .o_tx_msg_valid      (valid),
        .o_grant             (grant),
        .o_done              (done),
        .o_timeout_err       (tout),
        .o_falling_edge_busy (fall)
    );

    typedef struct packed {
        logic [3:0] req;
        logic       busy;
        logic       flush;
        logic       fall;
        logic       valid;
        logic [3:0] enc;
        logic [3:0] grant;
        logic [3:0] done;
        logic       tout;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (valid) n_valid++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        req   = '0;
        busy  = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_enc"},   32'(enc),   0);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_done"},  32'(done),  0);
        chk({tag, "_tout"},  32'(tout),  0);
        chk({tag, "_fall"},  32'(fall),  0);
    endtask

    initial begin
        // req busy flush | fall valid enc grant done tout
        vecs[0]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 4'b0001, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0001, 4'b0000, 1'b0};
        vecs[2]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0001, 4'b0000, 1'b0};
        vecs[3]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0001, 4'b0000, 1'b0};
        vecs[4]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0001, 4'b0000, 1'b0};
        vecs[5]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0001, 4'b0000, 1'b0};
        vecs[6]  = '{4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0001, 4'b0001, 1'b0};
        vecs[7]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0};
        vecs[8]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 4'b0100, 4'b0000, 1'b0};
        vecs[9]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0100, 4'b0000, 1'b0};
        vecs[10] = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0100, 4'b0000, 1'b0};
        vecs[11] = '{4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0100, 4'b0100, 1'b0};
        vecs[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0};
        vecs[13] = '{4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 4'b1000, 4'b0000, 1'b0};
        vecs[14] = '{4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0};
        vecs[15] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0};
        vecs[16] = '{4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0};
        vecs[17] = '{4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0};
        vecs[18] = '{4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 4'b0010, 4'b0000, 1'b0};
        vecs[19] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0};

        rst_n = 1'b0;
        flush = 1'b0;
        req   = '0;
        busy  = 1'b0;
        msg   = 16'h5A73;
        #12;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle-by-cycle table: two completions, ptr check, flush in ISSUE, busy hold-off.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req   = vecs[i].req;
            busy  = vecs[i].busy;
            flush = vecs[i].flush;
            #1;
            chk($sformatf("v%0d_fall", i), 32'(fall), 32'(vecs[i].fall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d_enc", i),   32'(enc),   32'(vecs[i].enc));
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
            chk($sformatf("v%0d_done", i),  32'(done),  32'(vecs[i].done));
            chk($sformatf("v%0d_tout", i),  32'(tout),  32'(vecs[i].tout));
        end

        // Round robin with all four requesters held.
        do_reset();
        msg = 16'hDCBA;
        n_valid = 0;
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            logic [3:0] eg;
            logic [3:0] em;
            bit seen;
            eg = 4'b0001 << (t % 4);
            em = 4'hA + 4'(t % 4);
            seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                if (valid) seen = 1;
            end
            chk($sformatf("rr%0d_valid_seen", t), 32'(seen), 1);
            chk($sformatf("rr%0d_grant", t), 32'(grant), 32'(eg));
            chk($sformatf("rr%0d_enc", t), 32'(enc), 32'(em));
            busy = 1'b1;
            tick(); tick(); tick();
            busy = 1'b0;
            seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                if (done != 0) seen = 1;
            end
            chk($sformatf("rr%0d_done_seen", t), 32'(seen), 1);
            chk($sformatf("rr%0d_done", t), 32'(done), 32'(eg));
        end
        req = '0;
        tick(); tick(); tick();
        chk("rr_valid_count", 32'(n_valid), 5);

        // Busy never rises: one re-issue, then timeout, ptr advances.
        do_reset();
        msg = 16'h0009;
        req = 4'b0001;
        for (int t = 1; t <= 2*ATO + 2; t++) begin
            tick();
            chk($sformatf("to_t%0d_valid", t), 32'(valid), 32'(t == 1 || t == ATO + 1));
            if (valid) chk($sformatf("to_t%0d_enc", t), 32'(enc), 9);
            chk($sformatf("to_t%0d_tout", t), 32'(tout), 32'(t == 2*ATO + 1));
            chk($sformatf("to_t%0d_done", t), 32'(done), 0);
            if (tout) begin
                chk("to_grant_cleared", 32'(grant), 0);
                req = '0;
            end
        end
        req = 4'b0011;
        tick();
        chk("to_next_valid", 32'(valid), 1);
        chk("to_next_grant", 32'(grant), 32'(4'b0010));
        req = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Flush in WAIT_FREE: no done, ptr unchanged.
        do_reset();
        msg = 16'h0E00;
        req = 4'b0100;
        tick();
        chk("fl_valid", 32'(valid), 1);
        chk("fl_grant", 32'(grant), 32'(4'b0100));
        busy = 1'b1;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req = '0;
        chk("fl_grant_cleared", 32'(grant), 0);
        chk("fl_done", 32'(done), 0);
        chk("fl_valid_after", 32'(valid), 0);
        busy = 1'b0;
        #1;
        chk("fl_fall_broadcast", 32'(fall), 1);
        tick();
        chk("fl_no_done_on_idle_fall", 32'(done), 0);
        req = 4'b1100;
        tick();
        chk("fl_next_valid", 32'(valid), 1);
        chk("fl_next_grant", 32'(grant), 32'(4'b0100));
        req = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Busy rises on the same cycle the counter reaches its limit.
        do_reset();
        msg = 16'h0009;
        req = 4'b0001;
        for (int t = 1; t <= ATO; t++) tick();
        busy = 1'b1;
        tick();
        chk("co_no_reissue", 32'(valid), 0);
        chk("co_grant_held", 32'(grant), 32'(4'b0001));
        tick();
        chk("co_no_tout", 32'(tout), 0);
        busy = 1'b0;
        tick();
        chk("co_done", 32'(done), 32'(4'b0001));
        req = '0;
        tick();
        chk("co_grant_released", 32'(grant), 0);

        // Asynchronous reset mid-transaction.
        do_reset();
        req = 4'b0001;
        tick();
        busy = 1'b1;
        tick(); tick();
        chk("ar_grant_before", 32'(grant), 32'(4'b0001));
        rst_n = 1'b0;
        busy = 1'b0;
        #2;
        chk_idle_outputs("async_rst");
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_no_done_after", 32'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ltsm_sb_tx_arbiter.md
Name: ltsm_sb_tx_arbiter

Overview:
- Shares the single sideband (SB) transmit channel among up to N_REQ LTSM handshake requesters, e.g. the TX and RX halves of each substate handshake wrapper.
- Grants requesters round-robin and issues a one-cycle valid with the granted encoded message.
- Tracks SB busy rise and fall to detect completion, and reports done, timeout and falling-edge-of-busy back to the requesters.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- SB_MSG_WIDTH, 4, encoded SB message width.
- ACK_TIMEOUT, 8, cycles to wait for i_SB_Busy to rise after issue (≥2).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous abort; LTSM state change.
- i_req  in  N_REQ  per-requester request; held until o_done or o_timeout_err.
- i_msg  in  N_REQ*SB_MSG_WIDTH  encoded message of requester i at bits [i*W +: W].
- i_SB_Busy  in  1  1 = SB transmitter occupied.
- o_encoded_SB_msg  out  SB_MSG_WIDTH  message to SB; 0 when o_tx_msg_valid=0.
- o_tx_msg_valid  out  1  one-cycle issue strobe to SB.
- o_grant  out  N_REQ  one-hot owner, held from issue through completion.
- o_done  out  N_REQ  one-cycle completion pulse to the owner.
- o_timeout_err  out  1  one-cycle pulse when both issue attempts time out.
- o_falling_edge_busy  out  1  i_SB_Busy 1→0 detect, broadcast to requesters.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; busy_q 0; counter 0; retry flag 0.
- Falling-edge detect: o_falling_edge_busy = busy_q & ~i_SB_Busy, combinational. busy_q is a registered copy of i_SB_Busy.
- IDLE: if |i_req and i_SB_Busy=0:
  - Winner = first set req scanning from ptr upward with wrap (ptr, ptr+1, …, N_REQ-1, 0, …).
  - Latch winner index and its i_msg; set o_grant; go to ISSUE.
  - If i_SB_Busy=1, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - o_tx_msg_valid=1 and o_encoded_SB_msg = latched msg; both are registered Moore outputs.
  - Clear counter; go to WAIT_BUSY.
  - Latency: req sampled in IDLE at cycle k gives valid at cycle k+1.
- WAIT_BUSY:
  - If i_SB_Busy=1, go to WAIT_FREE.
  - Otherwise increment counter. When counter == ACK_TIMEOUT-1:
    - Retry flag 0: set it, go to ISSUE (re-issue the same latched msg).
    - Retry flag 1: pulse o_timeout_err, clear o_grant, advance ptr to winner+1 mod N_REQ, go to IDLE. No o_done.
- WAIT_FREE:
  - On o_falling_edge_busy=1, go to DONE.
  - No timeout in this state.
- DONE (1 cycle):
  - o_done[winner]=1; clear o_grant and retry flag; ptr = winner+1 mod N_REQ; go to IDLE.
  - No arbitration this cycle. The requester must drop i_req in the cycle o_done is seen, so it is not re-granted.
- Requester rules:
  - i_req deasserted mid-transaction is ignored; the transaction completes.
  - i_msg changes after the grant are ignored, because the msg is latched.
- Simultaneous events:
  - Busy rising in the same cycle the counter hits its limit: busy wins, go to WAIT_FREE.
  - A falling edge while in IDLE or WAIT_BUSY is not a completion; it is still broadcast.
- i_flush=1 in any state (priority over all transitions):
  - Next state IDLE; clear o_grant, o_tx_msg_valid, counter and retry flag.
  - No o_done and no o_timeout_err; ptr unchanged.
- Reset mid-operation: asynchronous return to reset values, with no pulses emitted.
- o_grant is never multi-hot. At most one of o_done / o_timeout_err pulses per transaction.

Test Plan:
- N_REQ=4. i_req=4'b0101 with msg0=4'h3, msg2=4'hA; busy rises 2 cycles after valid and falls 3 cycles later.
  → grant 0001, valid with 3; o_done[0] pulses in the cycle after the falling edge. Then grant 0100, valid with A; ptr=3.
- All 4 requesters held continuously, each transaction completed by SB.
  → grant order 0,1,2,3,0; exactly 5 valids; o_done order matches.
- Request with i_SB_Busy never rising.
  → valid at k+1, re-issue at k+1+ACK_TIMEOUT with the same msg; o_timeout_err pulses ACK_TIMEOUT cycles later; no o_done; ptr advances.
- i_SB_Busy=1 while i_req=0010.
  → no valid until busy=0; valid in the cycle after the first busy-low sample in IDLE.
- i_flush asserted in WAIT_FREE.
  → next cycle IDLE, o_grant=0, no o_done. A following request is granted from the unchanged ptr.
- Busy rise coincident with counter == ACK_TIMEOUT-1.
  → no re-issue; enter WAIT_FREE; completion via o_done.
